msx_bus_sequencer: RTL and testbench

- Converts single-word bus commands, typically from the SPI command front-end, into correctly timed MSX cartridge-slot bus cycles.
- Sequences the T1/T2/Tw/T3 states, drives the active-low strobes, honours nwait and returns read data.
- Generates msx_clk from the system clock so that every strobe edge is aligned to a T-state boundary.
- Sits between the SPI command decoder and the slot pins; the top level owns the tristate on data_bus.

---
 rtl/msx_bus_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_msx_bus_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/msx_bus_sequencer.sv
// Turns single-word bus commands into timed MSX slot cycles (T1/T2/[Tw]/T3/DONE); latency 3*TSTATE_DIV+1 clk plus TSTATE_DIV per wait state.
// cmd_ready is high only in IDLE, so a source must hold cmd_valid until accepted. Optional wait timeout: MSX_WAIT_TIMEOUT_EN.
module msx_bus_sequencer #(
    parameter int TSTATE_DIV = 16,
    parameter int WAIT_MAX   = 255
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_type,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic        cmd_slot,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] address,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        rd,
    output logic        wr,
    output logic        iorq,
    output logic        merq,
    output logic        sltsl,
    output logic        m1,
    output logic        rfsh,
    input  logic        nwait,
    output logic        msx_clk
);

    localparam int CW = (TSTATE_DIV > 2) ? $clog2(TSTATE_DIV) : 1;

    if (TSTATE_DIV < 4 || (TSTATE_DIV % 2) != 0 || WAIT_MAX < 1) begin : g_bad_param
        $error("msx_bus_sequencer: TSTATE_DIV must be even and >= 4, WAIT_MAX >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3,
        S_DONE
    } state_t;

    localparam logic [2:0] CT_MRD  = 3'b000;
    localparam logic [2:0] CT_MWR  = 3'b001;
    localparam logic [2:0] CT_IORD = 3'b010;
    localparam logic [2:0] CT_IOWR = 3'b011;
    localparam logic [2:0] CT_M1   = 3'b100;
    localparam logic [2:0] CT_RFSH = 3'b101;

    function automatic logic [2:0] f_norm(input logic [2:0] t);
        return (t[2] && t[1]) ? CT_MRD : t;
    endfunction

    function automatic logic f_is_rd(input logic [2:0] t);
        return (t == CT_MRD) || (t == CT_IORD) || (t == CT_M1);
    endfunction

    function automatic logic f_is_wr(input logic [2:0] t);
        return (t == CT_MWR) || (t == CT_IOWR);
    endfunction

    function automatic logic f_is_io(input logic [2:0] t);
        return (t == CT_IORD) || (t == CT_IOWR);
    endfunction

    function automatic logic f_is_slt(input logic [2:0] t);
        return (t == CT_MRD) || (t == CT_MWR) || (t == CT_M1);
    endfunction

    state_t      state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]  type_q, type_d;
    logic        slot_q, slot_d;
    logic [15:0] address_q, address_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;
    logic        rd_q, rd_d, wr_q, wr_d, iorq_q, iorq_d, merq_q, merq_d;
    logic        sltsl_q, sltsl_d, m1_q, m1_d, rfsh_q, rfsh_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        msx_clk_q, msx_clk_d;
    logic        accept, tick, in_cyc, in_bus, tmo;

`ifdef MSX_WAIT_TIMEOUT_EN
    localparam int WW = $clog2(WAIT_MAX + 1) > 0 ? $clog2(WAIT_MAX + 1) : 1;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          tmo_q, tmo_d;
    logic          rsp_err_q, rsp_err_d;
    assign tmo     = tmo_q;
    assign rsp_err = rsp_err_q;
`else
    assign tmo     = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign accept = cmd_valid && (state_q == S_IDLE);
    assign tick   = (count_q == CW'(TSTATE_DIV - 1));

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        slot_d      = slot_q;
        address_d   = address_q;
        data_out_d  = data_out_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MSX_WAIT_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        tmo_d       = tmo_q;
        rsp_err_d   = rsp_err_q;
`endif
        // Restarting the divider on accept makes T1 exactly one T-state long.
        if (accept || tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end

        if (accept) begin
            type_d    = f_norm(cmd_type);
            slot_d    = cmd_slot;
            address_d = cmd_addr;
            if (f_is_wr(f_norm(cmd_type))) begin
                data_out_d = cmd_wdata;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_T1;
            end
            S_T1: begin
                if (tick) begin
                    state_d = S_T2;
`ifdef MSX_WAIT_TIMEOUT_EN
                    wait_cnt_d = '0;
                    tmo_d      = 1'b0;
`endif
                end
            end
            S_T2: begin
                // Refresh never waits; IO always takes one mandatory Tw.
                if (tick) begin
                    if (type_q == CT_RFSH) begin
                        state_d = S_T3;
                    end else if (f_is_io(type_q) || !nwait) begin
                        state_d = S_TW;
                    end else begin
                        state_d = S_T3;
                    end
                end
            end
            S_TW: begin
                if (tick) begin
`ifdef MSX_WAIT_TIMEOUT_EN
                    wait_cnt_d = wait_cnt_q + WW'(1);
                    if (nwait) begin
                        state_d = S_T3;
                    end else if (wait_cnt_q == WW'(WAIT_MAX - 1)) begin
                        state_d = S_T3;
                        tmo_d   = 1'b1;
                    end
`else
                    if (nwait) state_d = S_T3;
`endif
                end
            end
            S_T3: begin
                if (tick) begin
                    state_d = S_DONE;
                    if (tmo) begin
                        rsp_rdata_d = 8'hFF;
                    end else if (f_is_rd(type_q)) begin
                        rsp_rdata_d = data_in;
                    end else begin
                        rsp_rdata_d = 8'h00;
                    end
`ifdef MSX_WAIT_TIMEOUT_EN
                    rsp_err_d = tmo_q;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every strobe is a flop aligned to a T-state edge.
        in_cyc      = (state_d == S_T1) || (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);
        in_bus      = (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);
        m1_d        = !(in_cyc && (type_d == CT_M1));
        rfsh_d      = !(in_cyc && (type_d == CT_RFSH));
        sltsl_d     = !(in_cyc && f_is_slt(type_d) && slot_d);
        data_oe_d   = in_cyc && f_is_wr(type_d);
        merq_d      = !(in_bus && !f_is_io(type_d));
        iorq_d      = !(in_bus && f_is_io(type_d));
        rd_d        = !(in_bus && f_is_rd(type_d));
        wr_d        = !(in_bus && f_is_wr(type_d));
        rsp_valid_d = (state_d == S_DONE);
        msx_clk_d   = (count_d < CW'(TSTATE_DIV / 2));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            type_q      <= CT_MRD;
            slot_q      <= 1'b0;
            address_q   <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            iorq_q      <= 1'b1;
            merq_q      <= 1'b1;
            sltsl_q     <= 1'b1;
            m1_q        <= 1'b1;
            rfsh_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            msx_clk_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            type_q      <= type_d;
            slot_q      <= slot_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            iorq_q      <= iorq_d;
            merq_q      <= merq_d;
            sltsl_q     <= sltsl_d;
            m1_q        <= m1_d;
            rfsh_q      <= rfsh_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            msx_clk_q   <= msx_clk_d;
        end
    end

`ifdef MSX_WAIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wait_cnt_q <= '0;
            tmo_q      <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            tmo_q      <= tmo_d;
            rsp_err_q  <= rsp_err_d;
        end
    end
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign address   = address_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign rd        = rd_q;
    assign wr        = wr_q;
    assign iorq      = iorq_q;
    assign merq      = merq_q;
    assign sltsl     = sltsl_q;
    assign m1        = m1_q;
    assign rfsh      = rfsh_q;
    assign msx_clk   = msx_clk_q;

endmodule

// File: tb/tb_msx_bus_sequencer.sv
// Directed bench for msx_bus_sequencer with TSTATE_DIV=4, WAIT_MAX=3.
// Latency is counted in rising edges after the accepting edge, up to the edge that consumes rsp_valid.
module tb_msx_bus_sequencer;

    localparam int DIV  = 4;
    localparam int WMAX = 3;

    logic        clk = 1'b0;
    logic        nreset;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_type;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        cmd_slot;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [15:0] address;
    logic [7:0]  data_out, data_in;
    logic        data_oe;
    logic        rd, wr, iorq, merq, sltsl, m1, rfsh;
    logic        nwait, msx_clk;

    always #5 clk = ~clk;

    msx_bus_sequencer #(.TSTATE_DIV(DIV), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_slot(cmd_slot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .rd(rd), .wr(wr), .iorq(iorq), .merq(merq), .sltsl(sltsl), .m1(m1), .rfsh(rfsh),
        .nwait(nwait), .msx_clk(msx_clk)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    int          lat, gap;
    int          c_rd, c_wr, c_merq, c_iorq, c_slt_merq, c_m1, c_rfsh, c_oe, c_oe_bad;
    logic [15:0] addr_t1;
    logic        rdy_t1, oe_t1, msx_s1, msx_s3, err_r;
    logic [7:0]  rdata_r;

    // Called at a falling edge; nwait is forced high from sample 'rel' on.
    task automatic run_cmd(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                           input logic sl, input int rel);
        lat = 0; gap = 0;
        c_rd = 0; c_wr = 0; c_merq = 0; c_iorq = 0; c_slt_merq = 0;
        c_m1 = 0; c_rfsh = 0; c_oe = 0; c_oe_bad = 0;
        while (!cmd_ready && gap < 50) begin
            @(negedge clk);
            gap++;
        end
        cmd_type = t; cmd_addr = a; cmd_wdata = wd; cmd_slot = sl; cmd_valid = 1'b1;
        @(posedge clk);
        for (int s = 1; s <= 200; s++) begin
            @(negedge clk);
            if (s == 1) begin
                cmd_valid = 1'b0;
                rdy_t1  = cmd_ready;
                oe_t1   = data_oe;
                addr_t1 = address;
                msx_s1  = msx_clk;
            end
            if (s == 3) msx_s3 = msx_clk;
            if (!rd) c_rd++;
            if (!wr) c_wr++;
            if (!merq) c_merq++;
            if (!iorq) c_iorq++;
            if (!sltsl && !merq) c_slt_merq++;
            if (!m1) c_m1++;
            if (!rfsh) c_rfsh++;
            if (data_oe) begin
                c_oe++;
                if (data_out !== wd) c_oe_bad++;
            end
            if (s >= rel) nwait = 1'b1;
            if (rsp_valid) begin
                lat     = s;
                rdata_r = rsp_rdata;
                err_r   = rsp_err;
                break;
            end
        end
    endtask

    int n_rsp;

    initial begin
        nreset = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_wdata = '0;
        cmd_slot = 1'b0; data_in = '0; nwait = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_strobes", {rd, wr, iorq, merq, sltsl, m1, rfsh}, 7'h7F);
        check_eq("rst_addr", address, 16'h0000);
        check_eq("rst_oe_vld_clk", {data_oe, rsp_valid, rsp_err, msx_clk}, 4'b0000);
        check_eq("rst_rdata", rsp_rdata, 8'h00);
        nreset = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", cmd_ready, 1'b1);

        // Memory read, slot selected, no wait
        data_in = 8'hA5;
        run_cmd(3'b000, 16'h4000, 8'h00, 1'b1, 1);
        check_eq("mrd_lat", lat, 13);
        check_eq("mrd_ready_t1", rdy_t1, 1'b0);
        check_eq("mrd_addr", addr_t1, 16'h4000);
        check_eq("mrd_msxclk", {msx_s1, msx_s3}, 2'b10);
        check_eq("mrd_merq", c_merq, 8);
        check_eq("mrd_rd", c_rd, 8);
        check_eq("mrd_sltsl", c_slt_merq, 8);
        check_eq("mrd_iorq_wr", c_iorq + c_wr, 0);
        check_eq("mrd_data", {err_r, rdata_r}, 9'h0A5);

        // Memory write, slot not selected
        run_cmd(3'b001, 16'h8001, 8'h3C, 1'b0, 1);
        check_eq("mwr_lat", lat, 13);
        check_eq("mwr_oe_t1", oe_t1, 1'b1);
        check_eq("mwr_oe_cnt", c_oe, 12);
        check_eq("mwr_oe_data", c_oe_bad, 0);
        check_eq("mwr_wr", c_wr, 8);
        check_eq("mwr_rd", c_rd, 0);
        check_eq("mwr_sltsl", c_slt_merq, 0);
        check_eq("mwr_rdata", rdata_r, 8'h00);

        // IO read: one mandatory wait state
        data_in = 8'h5A;
        run_cmd(3'b010, 16'h0098, 8'h00, 1'b1, 1);
        check_eq("iord_lat", lat, 17);
        check_eq("iord_iorq", c_iorq, 12);
        check_eq("iord_merq", c_merq, 0);
        check_eq("iord_rdata", rdata_r, 8'h5A);

        // Memory read held off for two ticks by nwait
        data_in = 8'h77;
        nwait = 1'b0;
        run_cmd(3'b000, 16'h1000, 8'h00, 1'b0, 13);
        check_eq("wait2_lat", lat, 21);
        check_eq("wait2_rd", c_rd, 16);
        check_eq("wait2_rdata", rdata_r, 8'h77);

        // Refresh ignores nwait entirely
        nwait = 1'b0;
        run_cmd(3'b101, 16'h007F, 8'h00, 1'b1, 1000);
        nwait = 1'b1;
        check_eq("rfsh_lat", lat, 13);
        check_eq("rfsh_rfsh", c_rfsh, 12);
        check_eq("rfsh_merq_rd", {c_merq[7:0], c_rd[7:0]}, {8'd8, 8'd0});
        check_eq("rfsh_rdata", rdata_r, 8'h00);

        // Type 11x behaves as memory read, issued back to back
        data_in = 8'hC3;
        run_cmd(3'b110, 16'h1234, 8'h00, 1'b1, 1);
        check_eq("b2b_gap", gap, 1);
        check_eq("t110_lat", lat, 13);
        check_eq("t110_rd_merq", {c_rd[7:0], c_merq[7:0]}, {8'd8, 8'd8});
        check_eq("t110_rdata", rdata_r, 8'hC3);

        // Opcode fetch
        data_in = 8'h99;
        run_cmd(3'b100, 16'h0000, 8'h00, 1'b1, 1);
        check_eq("m1_lat", lat, 13);
        check_eq("m1_cnt", c_m1, 12);
        check_eq("m1_rdata", rdata_r, 8'h99);

`ifdef MSX_WAIT_TIMEOUT_EN
        // nwait stuck low: abort after WAIT_MAX wait states
        data_in = 8'h12;
        nwait = 1'b0;
        run_cmd(3'b000, 16'h2000, 8'h00, 1'b1, 1000);
        nwait = 1'b1;
        check_eq("tmo_lat", lat, 25);
        check_eq("tmo_err", err_r, 1'b1);
        check_eq("tmo_rdata", rdata_r, 8'hFF);
`endif

        // Reset during T2 of a write
        @(negedge clk);
        cmd_type = 3'b001; cmd_addr = 16'hBEEF; cmd_wdata = 8'h55; cmd_slot = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        check_eq("rst2_wr_active", {wr, data_oe}, 2'b01);
        nreset = 1'b0;
        #1;
        check_eq("rst2_strobes", {rd, wr, iorq, merq, sltsl, m1, rfsh}, 7'h7F);
        check_eq("rst2_oe", data_oe, 1'b0);
        @(negedge clk);
        nreset = 1'b1;
        n_rsp = 0;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        check_eq("rst2_no_rsp", n_rsp, 0);
        check_eq("rst2_ready", cmd_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
